counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, counter and length width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester interval request, level, held until done or abort.
REQ-005 len0  input  WIDTH  terminal count for requester 0, stable while req[0] high.
REQ-006 len1  input  WIDTH  terminal count for requester 1, stable while req[1] high.
REQ-007 gnt  output  2  one-hot registered grant; zero when no owner.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 count  output  WIDTH  current value of the shared up counter.

Function
REQ-011 The block SHALL share one WIDTH-bit up counter between two requesters using FSM states IDLE, RUN, DONE.
REQ-012 IDLE: no req -> stay, count held at 0; any req -> select winner, latch its len into term, set gnt, clear count to 0, go RUN.
REQ-013 Arbitration SHALL be round-robin: rr pointer names the preferred requester; a lone requester always wins; after each DONE or abort the pointer moves to the other requester.
REQ-014 RUN: count SHALL increment by 1 per cycle starting at 0; in the cycle count == term, the FSM SHALL go to DONE next edge and count holds.
REQ-015 Interval latency: count spends exactly term+1 cycles in RUN; req sampled in IDLE at cycle k -> gnt high from cycle k+1 -> done high at cycle k+2+term.
REQ-016 DONE: done[owner] high for exactly one cycle, gnt held; next edge -> IDLE with gnt = 0, count = 0, pointer updated.
REQ-017 Requester SHALL drop req on the edge ending the done cycle; req still high in the following IDLE cycle is treated as a new request.
REQ-018 Abort: req[owner] low during RUN -> next edge IDLE, gnt = 0, count = 0, no done pulse, pointer updated.
REQ-019 Changes on the non-owner's req or on len inputs during RUN/DONE SHALL have no effect; term is fixed at grant.
REQ-020 len = 0 -> one RUN cycle with count 0, then DONE; len = 2^WIDTH-1 -> count reaches all-ones and stops, never wraps.
REQ-021 gnt and done SHALL never have more than one bit set; done bit SHALL equal the gnt bit of the same cycle.

Reset
REQ-022 rst high at any edge, including mid-RUN or DONE, SHALL force next cycle: state IDLE, gnt 0, done 0, busy 0, count 0, term 0, rr pointer = requester 0.
REQ-023 A done pulse pending at reset SHALL be discarded.

Structure
REQ-024 Package counter_arbiter_pkg SHALL hold the state enumeration (IDLE, RUN, DONE), NREQ = 2 and default WIDTH = 4.
REQ-025 The counter SHALL be a sub-module count_core (clk, rst, clr, en, count); counter_arbiter contains FSM, arbiter, term register and drives clr/en.

Verification
REQ-026 Single request: req[0]=1, len0=3 at cycle 0 -> gnt=01 cycle 1, count 0,1,2,3 cycles 1-4, done=01 cycle 5, gnt=00 cycle 6.
REQ-027 Contention: req=11, len0=2, len1=1 from reset -> requester 0 served first (done[0] cycle 4), requester 1 granted after one IDLE cycle, done[1] cycle 8.
REQ-028 Fairness: requester 0 re-requests at once after its done while req[1] stays high -> requester 1 wins the next IDLE.
REQ-029 Boundaries: len0=0 -> done cycle 2; len0=15 -> count reaches 15, done cycle 17, no wrap to 0 during RUN.
REQ-030 Abort/reset: drop req[0] at count=2 -> IDLE next cycle, no done; rst at count=5 -> all outputs 0 next cycle, pointer favors requester 0.

Source files
------------

// File: rtl/counter_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// counter_arbiter_pkg
// Shared definitions for the two-requester counter arbiter: FSM state
// enumeration, requester count and default counter width.
// -----------------------------------------------------------------------------
package counter_arbiter_pkg;

  localparam int NREQ          = 2;
  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_arbiter_count_core.sv
// -----------------------------------------------------------------------------
// count_core
// WIDTH-bit up counter shared by the arbiter. Clear wins over enable.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, forces count to 0
//   clr   : synchronous clear to 0
//   en    : increment by 1 when not cleared
//   count : current counter value
// -----------------------------------------------------------------------------
module count_core
  import counter_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
// Shares one up counter between two requesters. A round-robin arbiter picks an
// owner in IDLE, latches its terminal count, and the counter runs from 0 to
// that terminal value (RUN), followed by a single done pulse (DONE). The owner
// may abort by dropping its request during RUN.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   req   : per-requester level request
//   len0  : terminal count for requester 0
//   len1  : terminal count for requester 1
//   gnt   : one-hot registered grant, zero when no owner
//   done  : one-cycle completion pulse to the owner
//   busy  : high whenever not IDLE
//   count : shared counter value
// -----------------------------------------------------------------------------
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             rr_q, rr_d;     // index of the preferred requester

  logic             owner;          // index of the granted requester
  logic             winner;         // requester picked if granting now
  logic             abort;
  logic             at_term;
  logic             cnt_clr;
  logic             cnt_en;

  // gnt is one-hot, so bit 1 alone identifies the owner while granted.
  assign owner   = gnt_q[1];
  // Contention goes to the preferred requester; a lone requester always wins.
  assign winner  = (req == 2'b11) ? rr_q : req[1];
  assign abort   = (state_q == RUN) && !req[owner];
  assign at_term = (count == term_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      term_q  <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      term_q  <= term_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    term_d  = term_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = RUN;
          gnt_d   = winner ? 2'b10 : 2'b01;
          term_d  = winner ? len1 : len0;
        end
      end
      RUN: begin
        // Abort takes priority over reaching the terminal count.
        if (abort) begin
          state_d = IDLE;
          gnt_d   = '0;
          rr_d    = ~owner;
        end else if (at_term) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        rr_d    = ~owner;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    done    = (state_q == DONE) ? gnt_q : '0;
    busy    = (state_q != IDLE);
    // Counter sits at 0 outside RUN; it holds at the terminal value for the
    // DONE cycle because clear only takes effect on the edge leaving DONE.
    cnt_clr = (state_q != RUN) || abort;
    cnt_en  = (state_q == RUN) && !at_term;
  end

  assign gnt = gnt_q;

  count_core #(
    .WIDTH (WIDTH)
  ) u_count_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

endmodule

// File: tb/tb_counter_arbiter.sv
// -----------------------------------------------------------------------------
// tb_counter_arbiter
// Self-checking bench: directed scenarios with literal expectations followed by
// randomized protocol-respecting traffic, all compared every cycle against a
// transaction-level model (owner, elapsed cycles, terminal count, pointer).
// -----------------------------------------------------------------------------
module tb_counter_arbiter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] len0, len1;
  logic [1:0]   gnt, done;
  logic         busy;
  logic [W-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: owner (-1 none), cycles since grant, latched term, preferred index
  int m_owner = -1;
  int m_t     = 0;
  int m_term  = 0;
  int m_rr    = 0;

  counter_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len0  (len0),
    .len1  (len1),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  function automatic int exp_gnt();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  function automatic int exp_done();
    return (m_owner >= 0 && m_t == m_term + 1) ? exp_gnt() : 0;
  endfunction

  function automatic int exp_count();
    if (m_owner < 0) return 0;
    return (m_t < m_term) ? m_t : m_term;
  endfunction

  function automatic int exp_busy();
    return (m_owner >= 0) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one edge using the inputs seen at that edge.
  task automatic model_edge();
    int lens[2];
    lens[0] = int'(len0);
    lens[1] = int'(len1);
    if (rst) begin
      m_owner = -1; m_t = 0; m_term = 0; m_rr = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? m_rr : (req[0] ? 0 : 1);
        m_term  = lens[m_owner];
        m_t     = 0;
      end
    end else if (m_t == m_term + 1) begin
      m_rr = 1 - m_owner; m_owner = -1;
    end else if (!req[m_owner]) begin
      m_rr = 1 - m_owner; m_owner = -1;
    end else begin
      m_t++;
    end
  endtask

  // One clock: update model at the edge, then compare #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt",   int'(gnt),   exp_gnt());
    check("done",  int'(done),  exp_done());
    check("busy",  int'(busy),  exp_busy());
    check("count", int'(count), exp_count());
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_len(input int i, input int v);
    if (i == 0) len0 = W'(v);
    else        len1 = W'(v);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;

    // Single request, len0 = 3
    do_reset();
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    req = 2'b01; len0 = 4'd3;
    step();                                   // cycle 1
    check("single_gnt_c1", int'(gnt), 1);
    check("single_count_c1", int'(count), 0);
    step(); step(); step();                   // cycle 4
    check("single_count_c4", int'(count), 3);
    step();                                   // cycle 5
    check("single_done_c5", int'(done), 1);
    req = 2'b00;
    step();                                   // cycle 6
    check("single_gnt_c6", int'(gnt), 0);

    // Contention: requester 0 first, then 1 after an IDLE cycle
    do_reset();
    req = 2'b11; len0 = 4'd2; len1 = 4'd1;
    repeat (4) step();                        // cycle 4
    check("cont_done0_c4", int'(done), 1);
    req = 2'b10;
    step();                                   // cycle 5
    check("cont_idle_c5", int'(busy), 0);
    step();                                   // cycle 6
    check("cont_gnt1_c6", int'(gnt), 2);
    step(); step();                           // cycle 8
    check("cont_done1_c8", int'(done), 2);
    req = 2'b00;
    step();

    // Fairness: requester 0 keeps req high after its done
    do_reset();
    req = 2'b11; len0 = 4'd1; len1 = 4'd1;
    repeat (3) step();                        // cycle 3
    check("fair_done0_c3", int'(done), 1);
    step();                                   // cycle 4, IDLE
    step();                                   // cycle 5
    check("fair_gnt1_c5", int'(gnt), 2);
    req = 2'b00;
    step();

    // Boundaries: len 0 and len all-ones
    do_reset();
    req = 2'b01; len0 = 4'd0;
    step();
    check("len0_count_c1", int'(count), 0);
    step();
    check("len0_done_c2", int'(done), 1);
    req = 2'b00;
    step();
    do_reset();
    req = 2'b01; len0 = W'(MAXV);
    repeat (16) step();                       // cycle 16
    check("max_count_c16", int'(count), 15);
    check("max_nodone_c16", int'(done), 0);
    step();                                   // cycle 17
    check("max_done_c17", int'(done), 1);
    check("max_hold_c17", int'(count), 15);
    req = 2'b00;
    step();
    check("max_clear", int'(count), 0);

    // Abort at count 2, then reset mid-RUN at count 5
    do_reset();
    req = 2'b01; len0 = 4'd10;
    repeat (3) step();                        // cycle 3
    check("abort_count_c3", int'(count), 2);
    req = 2'b00;
    step();                                   // cycle 4
    check("abort_gnt_c4", int'(gnt), 0);
    check("abort_done_c4", int'(done), 0);
    req = 2'b01;
    repeat (6) step();                        // cycle 10
    check("rst_mid_count", int'(count), 5);
    rst = 1'b1; req = 2'b00;
    step();
    check("rst_mid_gnt", int'(gnt), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_count0", int'(count), 0);
    rst = 1'b0; req = 2'b11; len0 = 4'd1; len1 = 4'd1;
    step();
    check("rst_ptr_gnt0", int'(gnt), 1);
    req = 2'b00;
    step();

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom % 250 == 0);
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) begin
          if ($urandom % 4 == 0) begin
            int r;
            r = int'($urandom % 8);
            set_len(i, (r == 0) ? 0 : (r == 1) ? MAXV : int'($urandom % 6));
            req[i] = 1'b1;
          end
        end else if (m_owner == i) begin
          if (exp_done() != 0)          req[i] = ($urandom % 4 == 0);
          else if ($urandom % 20 == 0)  req[i] = 1'b0;
          else if ($urandom % 8 == 0)   set_len(i, int'($urandom % 16));
        end else if ($urandom % 40 == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
